// File: rtl/eth_rx_frame_writer_pkg.sv
// Shared types and constants for the Ethernet RX frame writer.
package eth_rx_pkg;

   localparam int SLOT_BYTES = 2048;
   localparam int OFF_BITS   = 11;
   // Default slot-index width; the done_info slot field is sized from it.
   localparam int SLOT_W     = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DROP = 2'd2
   } rx_state_e;

   typedef struct packed {
      logic [SLOT_W-1:0]   slot;
      logic [OFF_BITS-1:0] len;
   } done_info_t;

endpackage

// File: rtl/eth_rx_frame_writer_if.sv
// RX MAC byte stream and RX buffer write port, bundled for the frame writer.
interface eth_rx_frame_writer_if #(
   parameter int SLOT_BITS = 3
);
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  rx_last;
   logic                  rx_err;
   logic                  mem_en;
   logic [1:0]            mem_we;
   logic [SLOT_BITS+9:0]  mem_addr;
   logic [15:0]           mem_din;

   // Source of the byte stream / sink of buffer writes (MAC + memory side).
   modport master (
      output rx_valid, rx_data, rx_last, rx_err,
      input  mem_en, mem_we, mem_addr, mem_din
   );

   // The frame writer itself.
   modport slave (
      input  rx_valid, rx_data, rx_last, rx_err,
      output mem_en, mem_we, mem_addr, mem_din
   );
endinterface

// File: rtl/eth_rx_slot_tracker.sv
// Ring of RX buffer slots: write/read pointers carry one extra wrap bit so
// occupancy is simply their difference.
module eth_rx_slot_tracker #(
   parameter int SLOT_BITS = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 commit_i,
   input  logic                 release_i,
   output logic [SLOT_BITS-1:0] wr_slot_o,
   output logic [SLOT_BITS:0]   full_cnt_o,
   output logic                 full_o
);
   logic [SLOT_BITS:0] wr_q, wr_d, rd_q, rd_d;
   logic               rel_ok;

   assign full_cnt_o = wr_q - rd_q;
   assign full_o     = (full_cnt_o == {1'b1, {SLOT_BITS{1'b0}}});
   assign wr_slot_o  = wr_q[SLOT_BITS-1:0];
   assign rel_ok     = release_i && (full_cnt_o != '0);

   // Advance pointers; a release on an empty ring is ignored.
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (commit_i) wr_d = wr_q + 1'b1;
      if (rel_ok)   rd_d = rd_q + 1'b1;
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
endmodule

// File: rtl/eth_rx_frame_writer.sv
// Ethernet RX frame writer: steers MAC bytes into byte lanes of the RX buffer,
// commits good frames to slots and counts dropped ones.
// Option: define ETH_RX_FCS_STRIP_EN to report frame length without the FCS.
module eth_rx_frame_writer
   import eth_rx_pkg::*;
#(
   parameter int SLOT_BITS = SLOT_W,
   parameter int MAX_LEN   = 1536,
   parameter int MIN_LEN   = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   eth_rx_frame_writer_if.slave   bus,
   output logic                   done_valid,
   output logic [SLOT_BITS-1:0]   done_slot,
   output logic [OFF_BITS-1:0]    done_len,
   input  logic                   rel_valid,
   output logic [SLOT_BITS:0]     full_cnt,
   output logic [15:0]            drop_cnt
);
   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RECV = ST_RECV;
   localparam logic [1:0] S_DROP = ST_DROP;
   localparam logic [OFF_BITS-1:0] MAX_L = OFF_BITS'(MAX_LEN);
   localparam logic [OFF_BITS-1:0] MIN_L = OFF_BITS'(MIN_LEN);

   logic [1:0]            state_q, state_d;
   logic [OFF_BITS-1:0]   cnt_q, cnt_d, off, len_fin, rep_len;
   logic                  wr, end_frame, commit, drop;
   logic                  mem_en_q;
   logic [1:0]            mem_we_q;
   logic [SLOT_BITS+9:0]  mem_addr_q;
   logic [15:0]           mem_din_q;
   logic                  done_valid_q;
   done_info_t            done_q;
   logic [15:0]           drop_q;
   logic [SLOT_BITS-1:0]  wr_slot;
   logic                  slot_full;

   eth_rx_slot_tracker #(.SLOT_BITS(SLOT_BITS)) u_slots (
      .clk        (clk),
      .rst        (rst),
      .commit_i   (commit),
      .release_i  (rel_valid),
      .wr_slot_o  (wr_slot),
      .full_cnt_o (full_cnt),
      .full_o     (slot_full)
   );

`ifdef ETH_RX_FCS_STRIP_EN
   assign rep_len = len_fin - OFF_BITS'(4);
`else
   assign rep_len = len_fin;
`endif

   // Frame FSM: decide per byte whether it is written and how a frame ends.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      off       = cnt_q;
      wr        = 1'b0;
      end_frame = 1'b0;
      drop      = 1'b0;
      len_fin   = (state_q == S_IDLE) ? OFF_BITS'(1) : cnt_q + OFF_BITS'(1);
      case (state_q)
         S_IDLE: if (bus.rx_valid) begin
            if (slot_full) begin
               if (bus.rx_last) drop = 1'b1;
               else             state_d = S_DROP;
            end else begin
               wr    = 1'b1;
               off   = '0;
               cnt_d = OFF_BITS'(1);
               if (bus.rx_last) end_frame = 1'b1;
               else             state_d = S_RECV;
            end
         end
         S_RECV: if (bus.rx_valid) begin
            if (cnt_q == MAX_L) begin
               // Oversize: this byte would be MAX_LEN+1, never write it.
               if (bus.rx_last) begin
                  drop    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DROP;
               end
            end else begin
               wr    = 1'b1;
               cnt_d = cnt_q + OFF_BITS'(1);
               if (bus.rx_last) begin
                  end_frame = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         S_DROP: if (bus.rx_valid && bus.rx_last) begin
            drop    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      commit = end_frame && !bus.rx_err && (len_fin >= MIN_L);
      if (end_frame && !commit) drop = 1'b1;
   end

   // State, buffer write port, commit report and drop counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 2'b00;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         done_valid_q <= 1'b0;
         done_q       <= '0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mem_en_q     <= wr;
         mem_we_q     <= wr ? (off[0] ? 2'b10 : 2'b01) : 2'b00;
         done_valid_q <= commit;
         if (wr) begin
            mem_addr_q <= {wr_slot, off[OFF_BITS-1:1]};
            mem_din_q  <= {bus.rx_data, bus.rx_data};
         end
         if (commit) done_q <= '{slot: wr_slot, len: rep_len};
         if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
   end

   assign bus.mem_en   = mem_en_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_din  = mem_din_q;
   assign done_valid   = done_valid_q;
   assign done_slot    = done_q.slot;
   assign done_len     = done_q.len;
   assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Self-checking bench for eth_rx_frame_writer: directed test-plan steps then
// random frames, compared against a per-frame reference model.
module tb_eth_rx_frame_writer;
   localparam int SB    = 3;
   localparam int NSLOT = 1 << SB;
   localparam int MAXL  = 1536;
   localparam int MINL  = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          done_valid;
   logic [SB-1:0] done_slot;
   logic [10:0]   done_len;
   logic          rel_valid;
   logic [SB:0]   full_cnt;
   logic [15:0]   drop_cnt;

   int checks = 0, errors = 0;
   // Reference model state: next slot to fill, occupied slots, drops.
   int exp_wr = 0, exp_full = 0, exp_drop = 0;

   always #5 clk = ~clk;

   eth_rx_frame_writer_if #(.SLOT_BITS(SB)) bus ();

   eth_rx_frame_writer #(.SLOT_BITS(SB), .MAX_LEN(MAXL), .MIN_LEN(MINL)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .done_valid (done_valid),
      .done_slot  (done_slot),
      .done_len   (done_len),
      .rel_valid  (rel_valid),
      .full_cnt   (full_cnt),
      .drop_cnt   (drop_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.rx_valid = 1'b0;
      bus.rx_last  = 1'b0;
      bus.rx_err   = 1'b0;
      rel_valid    = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_en"},   32'(bus.mem_en), 0);
      chk({tag, "_we"},   32'(bus.mem_we), 0);
      chk({tag, "_addr"}, 32'(bus.mem_addr), 0);
      chk({tag, "_din"},  32'(bus.mem_din), 0);
      chk({tag, "_dv"},   32'(done_valid), 0);
      chk({tag, "_slot"}, 32'(done_slot), 0);
      chk({tag, "_len"},  32'(done_len), 0);
      chk({tag, "_full"}, 32'(full_cnt), 0);
      chk({tag, "_drop"}, 32'(drop_cnt), 0);
   endtask

   // Expected write for byte i of a frame going to slot exp_wr.
   task automatic chk_write(input int i, input logic [7:0] b, input bit written);
      if (written) begin
         chk("mem_en",   32'(bus.mem_en), 1);
         chk("mem_we",   32'(bus.mem_we), (i % 2 == 1) ? 2 : 1);
         chk("mem_addr", 32'(bus.mem_addr), 32'(exp_wr * 1024 + i / 2));
         chk("mem_din",  32'(bus.mem_din), {16'h0, b, b});
      end else begin
         chk("nowr_en", 32'(bus.mem_en), 0);
         chk("nowr_we", 32'(bus.mem_we), 0);
      end
   endtask

   // Send one frame; each byte is checked the cycle after it is taken.
   task automatic send_frame(input int len, input bit err, input bit rel_last,
                             input logic [7:0] seed, input int gap_pct);
      bit   blocked = (exp_full == NSLOT);
      bit   commit;
      bit   rel_ok;
      int   rep;
      logic [7:0] b;
      for (int i = 0; i < len; i++) begin
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            idle_inputs();
            @(negedge clk);
            chk("gap_en", 32'(bus.mem_en), 0);
            chk("gap_dv", 32'(done_valid), 0);
         end
         b = seed ^ 8'(i);
         bus.rx_valid = 1'b1;
         bus.rx_data  = b;
         bus.rx_last  = (i == len - 1);
         bus.rx_err   = (i == len - 1) ? err : 1'($urandom_range(1));
         rel_valid    = rel_last && (i == len - 1);
         @(negedge clk);
         idle_inputs();
         chk_write(i, b, !blocked && i < MAXL);
         if (i == len - 1) begin
            commit = !blocked && len <= MAXL && len >= MINL && !err;
            rel_ok = rel_last && exp_full > 0;
            chk("done_valid", 32'(done_valid), 32'(commit));
            if (commit) begin
`ifdef ETH_RX_FCS_STRIP_EN
               rep = len - 4;
`else
               rep = len;
`endif
               chk("done_slot", 32'(done_slot), 32'(exp_wr));
               chk("done_len",  32'(done_len), 32'(rep));
               exp_wr   = (exp_wr + 1) % NSLOT;
               exp_full = exp_full + 1;
            end else if (exp_drop < 16'hFFFF) begin
               exp_drop = exp_drop + 1;
            end
            if (rel_ok) exp_full = exp_full - 1;
            chk("full_cnt", 32'(full_cnt), 32'(exp_full));
            chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
         end else begin
            chk("done_idle", 32'(done_valid), 0);
         end
      end
   endtask

   task automatic rel();
      rel_valid = 1'b1;
      @(negedge clk);
      rel_valid = 1'b0;
      if (exp_full > 0) exp_full = exp_full - 1;
      chk("rel_full", 32'(full_cnt), 32'(exp_full));
      chk("rel_dv", 32'(done_valid), 0);
   endtask

   initial begin
      int len;
      rst = 1'b1;
      bus.rx_data = 8'h00;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // 64-byte good frame, bytes 0x00..0x3F, lands in slot 0.
      send_frame(64, 1'b0, 1'b0, 8'h00, 0);

      // Fill all slots, overflow frame is dropped, release frees one.
      for (int k = 1; k < NSLOT; k++) send_frame(100, 1'b0, 1'b0, 8'($urandom), 10);
      send_frame(100, 1'b0, 1'b0, 8'h5A, 0);
      rel();
      send_frame(100, 1'b0, 1'b0, 8'hA5, 0);
      for (int k = 0; k <= NSLOT; k++) rel();

      // Errored frame dropped, next good frame reuses the slot.
      send_frame(200, 1'b1, 1'b0, 8'h11, 0);
      send_frame(80, 1'b0, 1'b0, 8'h22, 5);

      // Oversize, runt, and length boundaries.
      send_frame(1600, 1'b0, 1'b0, 8'h33, 0);
      send_frame(40, 1'b0, 1'b0, 8'h44, 0);
      send_frame(MINL - 1, 1'b0, 1'b0, 8'h55, 0);
      send_frame(1, 1'b0, 1'b0, 8'h66, 0);
      send_frame(MAXL, 1'b0, 1'b0, 8'h77, 0);
      send_frame(MAXL + 1, 1'b0, 1'b0, 8'h88, 0);

      // Commit and release in the same cycle with three slots full.
      while (exp_full > 0) rel();
      for (int k = 0; k < 3; k++) send_frame(70, 1'b0, 1'b0, 8'($urandom), 0);
      send_frame(70, 1'b0, 1'b1, 8'h99, 0);
      for (int k = 0; k < 4; k++) rel();
      send_frame(64, 1'b0, 1'b0, 8'hAB, 0);

      // Reset after byte 30 of a frame aborts it without a drop.
      for (int i = 0; i < 30; i++) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = 8'(i + 3);
         @(negedge clk);
         idle_inputs();
         chk_write(i, 8'(i + 3), exp_full < NSLOT);
      end
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("midrst");
      rst = 1'b0;
      exp_wr = 0; exp_full = 0; exp_drop = 0;
      @(negedge clk);
      send_frame(64, 1'b0, 1'b0, 8'hC3, 0);

      // Random frames against the model.
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(3) == 0) rel();
         len = ($urandom_range(9) == 0) ? int'($urandom_range(1530, 1545))
                                        : int'($urandom_range(1, 150));
         send_frame(len, $urandom_range(7) == 0, $urandom_range(3) == 0,
                    8'($urandom), 5);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/eth_rx_frame_writer.md
Name: eth_rx_frame_writer

Overview:
- Upstream stage of the Ethernet RX buffer memory. Takes the received byte stream from the RX MAC and writes each byte into a byte-lane of the 16-bit write port of the dual-port RX buffer.
- The buffer is split into 2^SLOT_BITS slots of 2048 bytes each. The block tracks which slots are full, reports each committed frame to the CPU-side register block, and drops frames that are bad, oversize or runt, or that arrive when no slot is free.

Parameters:
- SLOT_BITS, 3, log2 of slot count; buffer address width = SLOT_BITS+10.
- MAX_LEN, 1536, largest accepted frame in bytes, including FCS.
- MIN_LEN, 64, smallest accepted frame in bytes, including FCS.

Ports:
- clk  in  1  block clock; also used for the buffer write port.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  byte strobe from the RX MAC; no backpressure.
- rx_data  in  8  received byte.
- rx_last  in  1  qualifies the final byte of a frame.
- rx_err  in  1  sampled with rx_last; 1 = CRC or PHY error.
- mem_en  out  1  buffer port enable.
- mem_we  out  2  byte write enables.
- mem_addr  out  SLOT_BITS+10  halfword address: {slot, offset[10:1]}.
- mem_din  out  16  {rx_data, rx_data}.
- done_valid  out  1  one-cycle pulse: a frame was committed.
- done_slot  out  SLOT_BITS  slot of the committed frame.
- done_len  out  11  committed frame length in bytes.
- rel_valid  in  1  CPU frees the oldest full slot.
- full_cnt  out  SLOT_BITS+1  number of occupied slots.
- drop_cnt  out  16  dropped-frame counter, saturates at 0xFFFF.

Behaviour:
- Reset: all outputs 0; state IDLE; wr_ptr=rd_ptr=0; byte count=0.
- Reset mid-frame aborts the frame. Nothing is committed and drop_cnt is not incremented.
- Memory write latency: one cycle. A byte accepted in cycle N produces mem_en=1 in cycle N+1 with:
  - mem_we = 2'b01 when byte offset is even, 2'b10 when odd;
  - mem_addr = {wr_ptr, offset[10:1]}.
  - In all other cycles mem_en=0 and mem_we=0.
- FSM:
  - IDLE: on rx_valid, if full_cnt == 2^SLOT_BITS go to DROP (the byte is not written). Otherwise write the byte at offset 0, set count=1 and go to RECV.
  - RECV: each rx_valid writes at offset=count, then count++.
    - If count reaches MAX_LEN and another byte arrives without rx_last, go to DROP; that byte is not written.
    - On rx_last, go to IDLE and evaluate the frame:
      - error if rx_err=1, or if the final length (count including the last byte) is below MIN_LEN;
      - error → no commit, drop_cnt++;
      - otherwise commit.
  - DROP: ignore bytes and write nothing. On rx_last, drop_cnt++ and go to IDLE.
  - A single-byte frame (rx_last on the IDLE byte) is judged against MIN_LEN immediately.
- Commit:
  - The cycle after rx_last: done_valid=1, done_slot=wr_ptr, done_len=length (see the optional feature).
  - Same cycle: wr_ptr++ (wraps modulo slot count), full_cnt++.
  - done_slot and done_len hold until the next commit.
- Release: rel_valid with full_cnt>0 → rd_ptr++ and full_cnt--. rel_valid with full_cnt=0 is ignored.
- Commit and release in the same cycle: full_cnt unchanged; both pointers advance.
- A release that occurs during IDLE makes a slot available to the very next frame start.
- rx_valid=0 cycles inside a frame are allowed; the state holds.

Optional Feature:
- Macro: ETH_RX_FCS_STRIP_EN.
- Defined: done_len = byte count − 4. The FCS bytes are still written to the buffer. MIN_LEN and MAX_LEN checks still use the count including FCS.
- Undefined: done_len = byte count.

Decomposition:
- Package eth_rx_pkg holds:
  - the state enum (IDLE, RECV, DROP);
  - constants SLOT_BYTES=2048 and OFF_BITS=11;
  - a done_info struct {slot, len}.
- One sub-module, eth_rx_slot_tracker: wr_ptr, rd_ptr and full_cnt, driven by commit/release inputs, with a full flag as output.

Test Plan:
- 64-byte good frame, bytes 0x00..0x3F, after reset → 64 writes to addresses 0..31 with mem_we alternating 01/10. done_valid at cycle after last; done_slot=0, done_len=64 (60 with ETH_RX_FCS_STRIP_EN). full_cnt=1.
- 8 good 100-byte frames with no release, then a 9th → 9th frame writes nothing, drop_cnt=1, full_cnt=8. One rel_valid, then a 10th frame → committed to slot 0, full_cnt=8.
- 200-byte frame with rx_err=1 on last → no done_valid, drop_cnt=1. Next good frame lands in the same slot.
- 1600-byte frame with MAX_LEN=1536 → exactly 1536 writes, then DROP; no commit, drop_cnt=1. A 40-byte runt → drop_cnt=2.
- rel_valid asserted in the same cycle as a commit with full_cnt=3 → full_cnt stays 3, rd_ptr and wr_ptr both advance. rel_valid with full_cnt=0 → no change.
- rst asserted after byte 30 of a frame → all outputs 0, no done_valid, drop_cnt=0. The next frame starts at address 0.
